// File: rtl/pdh_pkg.sv
// Shared types and constants for the PS-side command path into the core sub-modules.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pdh_pkg;

  // Command sequencer FSM encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } seq_state_t;

  // Command codes understood by the attached targets. The sequencer itself
  // forwards any code untouched; these only give the software side names.
  localparam logic [3:0] CMD_NOP      = 4'h0;
  localparam logic [3:0] CMD_SET_LED  = 4'h1;
  localparam logic [3:0] CMD_SET_DAC  = 4'h2;
  localparam logic [3:0] CMD_READ_ADC = 4'h3;
  localparam logic [3:0] CMD_SET_PID  = 4'h4;

  // Cycles between the enable pulse and callback capture (legal 1..255).
  localparam int DEFAULT_SETTLE_CYCLES = 4;

endpackage

// File: rtl/cmd_sequencer.sv
// Sequences one PS command at a time into one of NUM_TARGETS sub-modules and returns its callback.
// Latency: enable pulse 1 cycle after acceptance, response valid SETTLE_CYCLES+2 cycles after acceptance.
// Backpressure: cmd_ready_o low from acceptance until after the response handshake; RESPOND holds while rsp_ready_i is low.
//
// Ports:
//   clk, rst_ni                         clock, async active-low reset
//   cmd_valid_i/cmd_ready_o             request handshake
//   cmd_i, target_i, payload_i          request fields (latched on acceptance)
//   tgt_cmd_o, tgt_payload_o            registered broadcast to every target, held between commands
//   tgt_en_o                            one-hot, single-cycle enable to the selected target
//   tgt_callback_i                      target k callback at [k*CALLBACK_WIDTH +: CALLBACK_WIDTH]
//   rsp_valid_o/rsp_ready_i             response handshake
//   rsp_callback_o, rsp_target_o, rsp_err_o  response fields, stable while rsp_valid_o is high
//   busy_o                              high whenever the FSM is not in IDLE
module cmd_sequencer
  import pdh_pkg::*;
#(
  parameter int NUM_TARGETS    = 4,
  parameter int CMD_WIDTH      = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int CALLBACK_WIDTH = 8,
  parameter int SETTLE_CYCLES  = DEFAULT_SETTLE_CYCLES,
  localparam int TGT_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_ni,
  input  logic                                  cmd_valid_i,
  output logic                                  cmd_ready_o,
  input  logic [CMD_WIDTH-1:0]                  cmd_i,
  input  logic [TGT_W-1:0]                      target_i,
  input  logic [DATA_WIDTH-1:0]                 payload_i,
  output logic [CMD_WIDTH-1:0]                  tgt_cmd_o,
  output logic [DATA_WIDTH-1:0]                 tgt_payload_o,
  output logic [NUM_TARGETS-1:0]                tgt_en_o,
  input  logic [NUM_TARGETS*CALLBACK_WIDTH-1:0] tgt_callback_i,
  output logic                                  rsp_valid_o,
  input  logic                                  rsp_ready_i,
  output logic [CALLBACK_WIDTH-1:0]             rsp_callback_o,
  output logic [TGT_W-1:0]                      rsp_target_o,
  output logic                                  rsp_err_o,
  output logic                                  busy_o
);

  // 8 bits covers the full legal settle range of 1..255.
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_t              state;
  logic [CNT_W-1:0]        settle_cnt;

  logic [NUM_TARGETS-1:0]    en_dec;
  logic                      err_dec;
  logic [CALLBACK_WIDTH-1:0] cb_sel;

  // One-hot decode of the incoming target index. Any index that matches no
  // attached target (only possible when NUM_TARGETS is not a power of two)
  // leaves the enable vector empty and flags an error.
  always_comb begin
    en_dec  = '0;
    err_dec = 1'b1;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      if (target_i == TGT_W'(k)) begin
        en_dec[k] = 1'b1;
        err_dec   = 1'b0;
      end
    end
  end

  // Callback mux keyed on the latched target. An out-of-range index matches
  // no slice, so the selection falls through to zero.
  always_comb begin
    cb_sel = '0;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      if (rsp_target_o == TGT_W'(k)) begin
        cb_sel = tgt_callback_i[k*CALLBACK_WIDTH +: CALLBACK_WIDTH];
      end
    end
  end

  // Single FSM process; every output is a register. rsp_target_o doubles as
  // the latched target index so the echo and the mux select cannot diverge.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      settle_cnt     <= '0;
      cmd_ready_o    <= 1'b1;
      busy_o         <= 1'b0;
      tgt_cmd_o      <= '0;
      tgt_payload_o  <= '0;
      tgt_en_o       <= '0;
      rsp_valid_o    <= 1'b0;
      rsp_callback_o <= '0;
      rsp_target_o   <= '0;
      rsp_err_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            tgt_cmd_o      <= cmd_i;
            tgt_payload_o  <= payload_i;
            tgt_en_o       <= en_dec;
            rsp_target_o   <= target_i;
            rsp_err_o      <= err_dec;
            rsp_callback_o <= '0;
            cmd_ready_o    <= 1'b0;
            busy_o         <= 1'b1;
            state          <= ISSUE;
          end
        end

        ISSUE: begin
          tgt_en_o   <= '0;
          settle_cnt <= SETTLE_LOAD;
          state      <= WAIT;
        end

        WAIT: begin
          if (settle_cnt == '0) begin
            rsp_callback_o <= rsp_err_o ? '0 : cb_sel;
            rsp_valid_o    <= 1'b1;
            state          <= RESPOND;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end

        RESPOND: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          tgt_en_o    <= '0;
          rsp_valid_o <= 1'b0;
          cmd_ready_o <= 1'b1;
          busy_o      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Testbench for cmd_sequencer: a 4-target and a 3-target instance, directed commands,
// expected enables and responses queued at issue time and popped by negedge monitors.
module tb_cmd_sequencer;

  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: NUM_TARGETS = 4
  logic        cv0 = 0, rr0 = 1;
  logic [3:0]  cmd0 = '0;
  logic [1:0]  tgt0 = '0;
  logic [7:0]  pl0 = '0;
  logic [31:0] cbb0 = '0;
  logic        cr0, rv0, rerr0, busy0;
  logic [3:0]  tcmd0, ten0;
  logic [7:0]  tpl0, rcb0;
  logic [1:0]  rtgt0;

  // Instance 1: NUM_TARGETS = 3 (index 3 is out of range)
  logic        cv1 = 0, rr1 = 1;
  logic [3:0]  cmd1 = '0;
  logic [1:0]  tgt1 = '0;
  logic [7:0]  pl1 = '0;
  logic [23:0] cbb1 = '0;
  logic        cr1, rv1, rerr1, busy1;
  logic [3:0]  tcmd1;
  logic [2:0]  ten1;
  logic [7:0]  tpl1, rcb1;
  logic [1:0]  rtgt1;

  cmd_sequencer #(.NUM_TARGETS(4), .CMD_WIDTH(4), .DATA_WIDTH(8), .CALLBACK_WIDTH(8),
                  .SETTLE_CYCLES(SETTLE)) dut4 (
    .clk(clk), .rst_ni(rst_n), .cmd_valid_i(cv0), .cmd_ready_o(cr0), .cmd_i(cmd0),
    .target_i(tgt0), .payload_i(pl0), .tgt_cmd_o(tcmd0), .tgt_payload_o(tpl0),
    .tgt_en_o(ten0), .tgt_callback_i(cbb0), .rsp_valid_o(rv0), .rsp_ready_i(rr0),
    .rsp_callback_o(rcb0), .rsp_target_o(rtgt0), .rsp_err_o(rerr0), .busy_o(busy0)
  );

  cmd_sequencer #(.NUM_TARGETS(3), .CMD_WIDTH(4), .DATA_WIDTH(8), .CALLBACK_WIDTH(8),
                  .SETTLE_CYCLES(SETTLE)) dut3 (
    .clk(clk), .rst_ni(rst_n), .cmd_valid_i(cv1), .cmd_ready_o(cr1), .cmd_i(cmd1),
    .target_i(tgt1), .payload_i(pl1), .tgt_cmd_o(tcmd1), .tgt_payload_o(tpl1),
    .tgt_en_o(ten1), .tgt_callback_i(cbb1), .rsp_valid_o(rv1), .rsp_ready_i(rr1),
    .rsp_callback_o(rcb1), .rsp_target_o(rtgt1), .rsp_err_o(rerr1), .busy_o(busy1)
  );

  typedef struct {
    logic [7:0] cb;
    logic [1:0] tgt;
    logic       err;
    int         acc;
  } rsp_exp_t;

  typedef struct {
    logic [3:0] en;
    logic [3:0] cmd;
    logic [7:0] pl;
    int         acc;
  } en_exp_t;

  rsp_exp_t rq0[$], rq1[$];
  en_exp_t  eq0[$], eq1[$];
  rsp_exp_t cur[2];
  logic     pv[2] = '{1'b0, 1'b0};
  int       hs[2] = '{-1, -1};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Enable monitor: any non-zero enable must match a queued expectation,
  // appear exactly one cycle after acceptance and carry the latched cmd/payload.
  task automatic mon_en(input int d, input logic [3:0] en, input logic [3:0] c, input logic [7:0] p);
    en_exp_t e;
    if (!rst_n || en == 4'd0) return;
    if ((d == 0 && eq0.size() == 0) || (d == 1 && eq1.size() == 0)) begin
      fail($sformatf("en_unexpected[%0d] en=0x%0h", d, en));
      return;
    end
    e = (d == 0) ? eq0.pop_front() : eq1.pop_front();
    check($sformatf("en_value[%0d]", d), 32'(en), 32'(e.en));
    check($sformatf("en_cycle[%0d]", d), cyc, e.acc + 1);
    check($sformatf("tgt_cmd[%0d]", d), 32'(c), 32'(e.cmd));
    check($sformatf("tgt_payload[%0d]", d), 32'(p), 32'(e.pl));
  endtask

  // Response monitor: on the rising valid, pop and compare fields and latency;
  // while valid stays high, the fields must not move.
  task automatic mon_rsp(input int d, input logic v, input logic r, input logic [7:0] cb,
                         input logic [1:0] t, input logic err);
    if (!rst_n) begin
      pv[d] = 1'b0;
      return;
    end
    if (v && !pv[d]) begin
      if ((d == 0 && rq0.size() == 0) || (d == 1 && rq1.size() == 0)) begin
        fail($sformatf("rsp_unexpected[%0d]", d));
        cur[d] = '{cb, t, err, 0};
      end else begin
        cur[d] = (d == 0) ? rq0.pop_front() : rq1.pop_front();
        check($sformatf("rsp_latency[%0d]", d), cyc, cur[d].acc + 2 + SETTLE);
        check($sformatf("rsp_callback[%0d]", d), 32'(cb), 32'(cur[d].cb));
        check($sformatf("rsp_target[%0d]", d), 32'(t), 32'(cur[d].tgt));
        check($sformatf("rsp_err[%0d]", d), 32'(err), 32'(cur[d].err));
      end
    end else if (v) begin
      check($sformatf("rsp_stable_cb[%0d]", d), 32'(cb), 32'(cur[d].cb));
      check($sformatf("rsp_stable_tgt[%0d]", d), 32'(t), 32'(cur[d].tgt));
      check($sformatf("rsp_stable_err[%0d]", d), 32'(err), 32'(cur[d].err));
    end
    if (v && r) hs[d] = cyc;
    pv[d] = v;
  endtask

  always @(negedge clk) begin
    mon_en(0, ten0, tcmd0, tpl0);
    mon_en(1, {1'b0, ten1}, tcmd1, tpl1);
    mon_rsp(0, rv0, rr0, rcb0, rtgt0, rerr0);
    mon_rsp(1, rv1, rr1, rcb1, rtgt1, rerr1);
  end

  // Target-0 model on instance 0: echoes the payload as its callback three
  // cycles after seeing its enable.
  initial begin
    logic [7:0] p;
    forever begin
      @(negedge clk);
      if (rst_n && ten0[0]) begin
        p = tpl0;
        repeat (3) @(negedge clk);
        cbb0[7:0] = p;
      end
    end
  end

  // Present one command; queue expectations at the moment acceptance is certain.
  task automatic send(input int d, input logic [3:0] c, input logic [1:0] t, input logic [7:0] p,
                      input logic [7:0] ecb, input logic eerr, output int acc);
    int  n;
    bit  done;
    logic [3:0] en_exp;
    @(negedge clk);
    if (d == 0) begin cv0 = 1; cmd0 = c; tgt0 = t; pl0 = p; end
    else        begin cv1 = 1; cmd1 = c; tgt1 = t; pl1 = p; end
    acc = -1; n = 0; done = 0;
    while (!done) begin
      if ((d == 0) ? cr0 : cr1) begin
        acc = cyc;
        en_exp = 4'd1 << t;
        if (d == 0) begin
          rq0.push_back('{ecb, t, eerr, acc});
          if (!eerr) eq0.push_back('{en_exp, c, p, acc});
        end else begin
          rq1.push_back('{ecb, t, eerr, acc});
          if (!eerr) eq1.push_back('{en_exp, c, p, acc});
        end
        done = 1;
        @(negedge clk);
      end else if (n >= 200) begin
        fail($sformatf("accept_timeout[%0d]", d));
        done = 1;
      end else begin
        n++;
        @(negedge clk);
      end
    end
    if (d == 0) cv0 = 0; else cv1 = 0;
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    while (n < 100 && (((d == 0) ? (rq0.size() != 0 || busy0) : (rq1.size() != 0 || busy1)))) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) fail($sformatf("done_timeout[%0d]", d));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_a, acc_b, acc_c;

    // Reset release with no request pending.
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("reset_ready0", 32'(cr0), 32'd1);
    check("reset_ready1", 32'(cr1), 32'd1);
    check("reset_outs0", {tcmd0, tpl0, ten0, rv0, rcb0, rtgt0, rerr0, busy0}, 32'd0);
    check("reset_outs1", {tcmd1, tpl1, ten1, rv1, rcb1, rtgt1, rerr1, busy1}, 32'd0);

    // Target 0 echoes payload A5.
    send(0, 4'h1, 2'd0, 8'hA5, 8'hA5, 1'b0, acc_a);
    wait_done(0);

    // Target 2 selected while target 0 shows a different callback.
    cbb0[7:0]   = 8'h11;
    cbb0[23:16] = 8'h3C;
    send(0, 4'h2, 2'd2, 8'h42, 8'h3C, 1'b0, acc_a);
    wait_done(0);
    check("hold_tgt_cmd", 32'(tcmd0), 32'h2);
    check("hold_tgt_payload", 32'(tpl0), 32'h42);

    // Out-of-range target on the 3-target instance, then a legal one.
    cbb1 = {8'h66, 8'h55, 8'h44};
    send(1, 4'h3, 2'd3, 8'h99, 8'h00, 1'b1, acc_a);
    wait_done(1);
    check("err_tgt_cmd", 32'(tcmd1), 32'h3);
    check("err_tgt_payload", 32'(tpl1), 32'h99);
    send(1, 4'h7, 2'd2, 8'h12, 8'h66, 1'b0, acc_a);
    wait_done(1);

    // Response back-pressure with a second request waiting.
    cbb0[15:8]  = 8'h77;
    cbb0[31:24] = 8'hE1;
    rr0 = 0;
    send(0, 4'h4, 2'd1, 8'h10, 8'h77, 1'b0, acc_a);
    fork
      send(0, 4'hF, 2'd3, 8'hC3, 8'hE1, 1'b0, acc_b);
      begin
        int n;
        n = 0;
        while (!rv0 && n < 50) begin n++; @(negedge clk); end
        if (!rv0) fail("bp_rsp_timeout");
        repeat (10) @(negedge clk);
        rr0 = 1;
      end
    join
    check("bp_accept_after_hs", acc_b, hs[0] + 1);
    wait_done(0);

    // Reset in the middle of WAIT.
    cbb0[15:8] = 8'h2B;
    send(0, 4'h1, 2'd1, 8'h07, 8'h2B, 1'b0, acc_a);
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    check("midwait_rst_outs", {tcmd0, tpl0, ten0, rv0, rcb0, rtgt0, rerr0, busy0}, 32'd0);
    rq0.delete();
    eq0.delete();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("midwait_rst_ready", 32'(cr0), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("midwait_no_rsp", 32'(rv0), 32'd0);
      @(negedge clk);
    end
    send(0, 4'h2, 2'd3, 8'h81, 8'hE1, 1'b0, acc_c);
    wait_done(0);

    repeat (3) @(negedge clk);
    if (rq0.size() != 0 || rq1.size() != 0 || eq0.size() != 0 || eq1.size() != 0)
      fail("leftover_expectations");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
